bin2bcd_conv: RTL and testbench
===============================

Name: bin2bcd_conv

Overview:
Parametrised serial binary-to-BCD converter built from DIGITS chained shift-add digit cells, using the subtract-5-and-carry form. It converts a BIN_W-bit binary word into DIGITS packed BCD digits. The block adds a start/busy/done handshake, an operand register and overflow detection. It sits between binary counters/datapaths and display/decoder logic.

Parameters:
BIN_W, 16, binary input width (≥2).
DIGITS, 5, number of BCD output digits (≥1).
CNT_W, $clog2(BIN_W+1), width of internal shift counter (derived; not overridden).

Ports:
CLK  input  1  clock; all state updates on rising edge.
INIT  input  1  synchronous active-high reset.
START  input  1  conversion request; sampled in IDLE or DONE state.
BIN  input  BIN_W  binary operand; captured on the edge that accepts START.
BUSY  output  1  high while in SHIFT state.
DONE  output  1  one-cycle pulse; BCD/OVF valid from this cycle on.
BCD  output  4*DIGITS  packed result; digit i at [4i+3:4i], digit 0 = units.
OVF  output  1  result exceeded DIGITS decimal digits; BCD then holds the value modulo 10^DIGITS.

Behaviour:
- Reset: INIT=1 at a rising edge → state IDLE, BCD=0, OVF=0, BUSY=0, DONE=0, shift register and counter cleared. INIT has priority over everything, including mid-conversion; a partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE --START--> SHIFT.
  - SHIFT --counter==BIN_W-1--> DONE.
  - DONE --START--> SHIFT; DONE --!START--> IDLE.
- Accept edge (edge 0): load the shift register with BIN, clear all digits, clear OVF, set counter=0, enter SHIFT.
- Shift edges 1..BIN_W: one shift per edge, MSB of the shift register first.
  - Per digit cell i with value Q: carry_out(i) = (Q ≥ 5).
  - If Q ≥ 5, Q ← {Q−5, carry_in}[3:0], written as ((Q−5)<<1)|carry_in; otherwise Q ← {Q[2:0], carry_in}.
  - carry_in(0) = current shift-register MSB; carry_in(i) = carry_out(i−1).
  - Shift register moves left by 1 and fills with 0.
  - Any edge with carry_out(DIGITS−1)=1 sets OVF (sticky until the next accept or reset).
  - Counter increments.
- Latency: START sampled at edge 0 → DONE=1 in the cycle after edge BIN_W, i.e. BIN_W+1 edges after acceptance.
- BCD is a registered output and changes only during SHIFT. Between DONE and the next accept it holds the last result; mid-conversion values are don't-care to consumers.
- START is ignored while BUSY=1, with no queuing. START in DONE state is accepted for back-to-back conversion: DONE pulses for exactly one cycle and BUSY rises on the next cycle.
- BIN is only sampled on the accept edge; changes afterwards have no effect.
- Digit values never exceed 9 in any cycle. Carry logic uses 4-bit compares; no width growth.

Optional Feature:
BIN2BCD_SIGNED_EN.
- Defined:
  - BIN is two's complement; an extra output SIGN (1 bit) is added, reset 0.
  - On accept: SIGN ← BIN[BIN_W−1] and the shift register loads |BIN|, computed in BIN_W bits.
  - The most-negative value −2^(BIN_W−1) converts as magnitude 2^(BIN_W−1), read unsigned.
  - SIGN is held with BCD.
- Undefined: BIN is unsigned, the SIGN port does not exist, and the magnitude logic is absent.

Test Plan:
- Defaults, INIT pulse → BCD=0x00000, OVF=0, BUSY=0, DONE=0. START with BIN=0 → DONE exactly 17 edges after accept, BCD=0x00000.
- BIN=16'd1234 → BCD=0x01234, OVF=0. BIN=16'd65535 → BCD=0x65535, BUSY high for 16 cycles.
- BIN_W=8, DIGITS=2, BIN=8'd255 → OVF=1, BCD=0x55. BIN=8'd99 → OVF=0, BCD=0x99.
- START held high continuously with BIN=1 then BIN=42 → second accept on the DONE cycle, BCD=0x00001 then 0x00042. START pulses during BUSY → ignored, no extra DONE.
- INIT asserted at edge 8 of a conversion of 65535 → next cycle IDLE, BCD=0, no DONE. A fresh START of 7 → BCD=0x00007.
- BIN2BCD_SIGNED_EN defined: BIN=16'hFFFF → SIGN=1, BCD=0x00001. BIN=16'h8000 → SIGN=1, BCD=0x32768. BIN=16'd500 → SIGN=0, BCD=0x00500.

Source files
------------

// File: rtl/bin2bcd_conv_if.sv
// Handshake and result bundle for bin2bcd_conv.
// Carries the SIGN output only when BIN2BCD_SIGNED_EN is defined.
interface bin2bcd_conv_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  START;
  logic [BIN_W-1:0]      BIN;
  logic                  BUSY;
  logic                  DONE;
  logic [4*DIGITS-1:0]   BCD;
  logic                  OVF;
`ifdef BIN2BCD_SIGNED_EN
  logic                  SIGN;

  modport master (output START, BIN, input BUSY, DONE, BCD, OVF, SIGN);
  modport slave  (input START, BIN, output BUSY, DONE, BCD, OVF, SIGN);
`else
  modport master (output START, BIN, input BUSY, DONE, BCD, OVF);
  modport slave  (input START, BIN, output BUSY, DONE, BCD, OVF);
`endif
endinterface

// File: rtl/bin2bcd_conv.sv
// Serial binary-to-BCD converter: one shift per clock through a chain of subtract-5 digit cells.
// Optional BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, SIGN output added.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for START, last result held
// ST_SHIFT | shifting operand into digit chain, BUSY high
// ST_DONE  | one-cycle DONE pulse; START here re-accepts
module bin2bcd_conv #(
  parameter  int BIN_W  = 16,
  parameter  int DIGITS = 5,
  localparam int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic              CLK,
  input  logic              INIT,
  bin2bcd_conv_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t                state_q, state_nxt;
  logic                  accept;
  logic [BIN_W-1:0]      sreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [4*DIGITS-1:0]   bcd_q, bcd_nxt;
  logic                  ovf_q;
  logic [DIGITS:0]       carry;
  logic [BIN_W-1:0]      load_val;

`ifdef BIN2BCD_SIGNED_EN
  logic                  sign_q;

  // -2^(BIN_W-1) negates to itself, which reads correctly as an unsigned magnitude
  assign load_val = bus.BIN[BIN_W-1] ? (~bus.BIN + BIN_W'(1)) : bus.BIN;
  assign bus.SIGN = sign_q;

  always_ff @(posedge CLK) begin
    if (INIT)
      sign_q <= 1'b0;
    else if (accept)
      sign_q <= bus.BIN[BIN_W-1];
  end
`else
  assign load_val = bus.BIN;
`endif

  always_ff @(posedge CLK) begin
    if (INIT)
      state_q <= ST_IDLE;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST)
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.START) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign carry[0] = sreg_q[BIN_W-1];

  // Each cell doubles its digit and adds carry-in; a digit >= 5 would reach 10, so it carries out
  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    logic [3:0] q;
    logic [2:0] sub;
    logic       ge5;

    assign q        = bcd_q[4*g +: 4];
    assign ge5      = (q >= 4'd5);
    assign sub      = q[2:0] - 3'd5;
    assign carry[g+1] = ge5;
    assign bcd_nxt[4*g +: 4] = ge5 ? {sub, carry[g]} : {q[2:0], carry[g]};
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      sreg_q <= load_val;
      cnt_q  <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      sreg_q <= {sreg_q[BIN_W-2:0], 1'b0};
      cnt_q  <= cnt_q + CNT_W'(1);
      bcd_q  <= bcd_nxt;
      if (carry[DIGITS])
        ovf_q <= 1'b1;
    end
  end

  assign bus.BUSY = (state_q == ST_SHIFT);
  assign bus.DONE = (state_q == ST_DONE);
  assign bus.BCD  = bcd_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed testbench for bin2bcd_conv: default 16-bit/5-digit instance plus an 8-bit/2-digit instance.
module tb_bin2bcd_conv;

  logic clk;
  logic init;
  int   assertions;
  int   failures;

  bin2bcd_conv_if #(.BIN_W(16), .DIGITS(5)) bus16 ();
  bin2bcd_conv_if #(.BIN_W(8),  .DIGITS(2)) bus8 ();

  bin2bcd_conv #(.BIN_W(16), .DIGITS(5)) u_dut16 (.CLK(clk), .INIT(init), .bus(bus16));
  bin2bcd_conv #(.BIN_W(8),  .DIGITS(2)) u_dut8  (.CLK(clk), .INIT(init), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges counted from the accept edge (inclusive) until DONE is seen
  task automatic run16(input logic [15:0] val, output int edges, output int busy_cyc);
    bus16.BIN   = val;
    bus16.START = 1'b1;
    edges    = 0;
    busy_cyc = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) bus16.START = 1'b0;
      if (bus16.BUSY) busy_cyc++;
    end while (!bus16.DONE && edges < 200);
  endtask

  task automatic run8(input logic [7:0] val, output int edges);
    bus8.BIN   = val;
    bus8.START = 1'b1;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) bus8.START = 1'b0;
    end while (!bus8.DONE && edges < 200);
  endtask

  task automatic test_reset;
    assertions++;
    if (bus16.BCD !== 20'h00000) begin failures++; $display("FAIL reset_bcd got %h want 00000", bus16.BCD); end
    assertions++;
    if (bus16.OVF !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", bus16.OVF); end
    assertions++;
    if (bus16.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus16.BUSY); end
    assertions++;
    if (bus16.DONE !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus16.DONE); end
    assertions++;
    if (bus8.BCD !== 8'h00 || bus8.OVF !== 1'b0) begin
      failures++; $display("FAIL reset_small got bcd=%h ovf=%b want 00/0", bus8.BCD, bus8.OVF);
    end
  endtask

  task automatic test_zero;
    int e, b;
    run16(16'd0, e, b);
    assertions++;
    if (e !== 17) begin failures++; $display("FAIL zero_latency got %0d edges want 17", e); end
    assertions++;
    if (bus16.BCD !== 20'h00000) begin failures++; $display("FAIL zero_bcd got %h want 00000", bus16.BCD); end
    @(negedge clk);
    assertions++;
    if (bus16.DONE !== 1'b0) begin failures++; $display("FAIL done_pulse_width got %b want 0", bus16.DONE); end
  endtask

  task automatic test_values;
    int e, b;
    run16(16'd1234, e, b);
    assertions++;
    if (e !== 17) begin failures++; $display("FAIL v1234_latency got %0d want 17", e); end
    assertions++;
    if (bus16.BCD !== 20'h01234 || bus16.OVF !== 1'b0) begin
      failures++; $display("FAIL v1234 got bcd=%h ovf=%b want 01234/0", bus16.BCD, bus16.OVF);
    end
    @(negedge clk);
    run16(16'd65535, e, b);
    assertions++;
    if (bus16.BCD !== 20'h65535 || bus16.OVF !== 1'b0) begin
      failures++; $display("FAIL v65535 got bcd=%h ovf=%b want 65535/0", bus16.BCD, bus16.OVF);
    end
    assertions++;
    if (b !== 16) begin failures++; $display("FAIL v65535_busy got %0d cycles want 16", b); end
    @(negedge clk);
    assertions++;
    if (bus16.BCD !== 20'h65535) begin failures++; $display("FAIL hold_bcd got %h want 65535", bus16.BCD); end
  endtask

  task automatic test_overflow;
    int e;
    run8(8'd255, e);
    assertions++;
    if (e !== 9) begin failures++; $display("FAIL small_latency got %0d want 9", e); end
    assertions++;
    if (bus8.OVF !== 1'b1 || bus8.BCD !== 8'h55) begin
      failures++; $display("FAIL ovf255 got bcd=%h ovf=%b want 55/1", bus8.BCD, bus8.OVF);
    end
    @(negedge clk);
    run8(8'd99, e);
    assertions++;
    if (bus8.OVF !== 1'b0 || bus8.BCD !== 8'h99) begin
      failures++; $display("FAIL v99 got bcd=%h ovf=%b want 99/0", bus8.BCD, bus8.OVF);
    end
    @(negedge clk);
    run8(8'd100, e);
    assertions++;
    if (bus8.OVF !== 1'b1 || bus8.BCD !== 8'h00) begin
      failures++; $display("FAIL ovf100 got bcd=%h ovf=%b want 00/1", bus8.BCD, bus8.OVF);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    bus16.BIN   = 16'd1;
    bus16.START = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus16.DONE && n < 200);
    assertions++;
    if (bus16.DONE !== 1'b1 || bus16.BCD !== 20'h00001) begin
      failures++; $display("FAIL b2b_first got done=%b bcd=%h want 1/00001", bus16.DONE, bus16.BCD);
    end
    bus16.BIN = 16'd42;
    @(negedge clk);
    assertions++;
    if (bus16.DONE !== 1'b0 || bus16.BUSY !== 1'b1) begin
      failures++; $display("FAIL b2b_reaccept got done=%b busy=%b want 0/1", bus16.DONE, bus16.BUSY);
    end
    n = 1;
    do begin @(negedge clk); n++; end while (!bus16.DONE && n < 200);
    assertions++;
    if (n !== 17 || bus16.BCD !== 20'h00042) begin
      failures++; $display("FAIL b2b_second got edges=%0d bcd=%h want 17/00042", n, bus16.BCD);
    end
    bus16.START = 1'b0;
    @(negedge clk);
    assertions++;
    if (bus16.DONE !== 1'b0 || bus16.BUSY !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got done=%b busy=%b want 0/0", bus16.DONE, bus16.BUSY);
    end
  endtask

  task automatic test_start_ignored;
    int dones;
    bus16.BIN   = 16'd300;
    bus16.START = 1'b1;
    @(negedge clk);
    bus16.START = 1'b0;
    dones = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3 || i == 9) begin
        bus16.BIN   = 16'd999;
        bus16.START = 1'b1;
      end else begin
        bus16.START = 1'b0;
      end
      @(negedge clk);
      if (bus16.DONE) dones++;
    end
    bus16.START = 1'b0;
    assertions++;
    if (dones !== 1) begin failures++; $display("FAIL busy_start_dones got %0d want 1", dones); end
    assertions++;
    if (bus16.BCD !== 20'h00300) begin failures++; $display("FAIL busy_start_bcd got %h want 00300", bus16.BCD); end
  endtask

  task automatic test_init_abort;
    int dones, e, b;
    bus16.BIN   = 16'd65535;
    bus16.START = 1'b1;
    @(negedge clk);
    bus16.START = 1'b0;
    repeat (7) @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    assertions++;
    if (bus16.BUSY !== 1'b0 || bus16.DONE !== 1'b0 || bus16.BCD !== 20'h00000) begin
      failures++; $display("FAIL abort_state got busy=%b done=%b bcd=%h want 0/0/00000",
                           bus16.BUSY, bus16.DONE, bus16.BCD);
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus16.DONE) dones++;
    end
    assertions++;
    if (dones !== 0) begin failures++; $display("FAIL abort_done got %0d pulses want 0", dones); end
    run16(16'd7, e, b);
    assertions++;
    if (bus16.BCD !== 20'h00007) begin failures++; $display("FAIL abort_fresh got %h want 00007", bus16.BCD); end
    @(negedge clk);
  endtask

`ifdef BIN2BCD_SIGNED_EN
  task automatic test_signed;
    int e, b;
    run16(16'hFFFF, e, b);
    assertions++;
    if (bus16.SIGN !== 1'b1 || bus16.BCD !== 20'h00001) begin
      failures++; $display("FAIL s_m1 got sign=%b bcd=%h want 1/00001", bus16.SIGN, bus16.BCD);
    end
    @(negedge clk);
    run16(16'h8000, e, b);
    assertions++;
    if (bus16.SIGN !== 1'b1 || bus16.BCD !== 20'h32768 || bus16.OVF !== 1'b0) begin
      failures++; $display("FAIL s_min got sign=%b bcd=%h ovf=%b want 1/32768/0", bus16.SIGN, bus16.BCD, bus16.OVF);
    end
    @(negedge clk);
    run16(16'd500, e, b);
    assertions++;
    if (bus16.SIGN !== 1'b0 || bus16.BCD !== 20'h00500) begin
      failures++; $display("FAIL s_500 got sign=%b bcd=%h want 0/00500", bus16.SIGN, bus16.BCD);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    assertions  = 0;
    failures    = 0;
    init        = 1'b1;
    bus16.START = 1'b0;
    bus16.BIN   = '0;
    bus8.START  = 1'b0;
    bus8.BIN    = '0;
    repeat (2) @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    test_reset();
`ifdef BIN2BCD_SIGNED_EN
    test_signed();
`else
    test_zero();
    test_values();
    test_overflow();
    test_back_to_back();
    test_start_ignored();
    test_init_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
